model: RTL and testbench
========================

MODEL -- requirements
Module: model

Interface
REQ-001 The block SHALL have parameter FIZZ, default 3: fizz divisor, legal range >=2.
REQ-002 The block SHALL have parameter BUZZ, default 5: buzz divisor, legal range >=2.
REQ-003 The block SHALL have parameter MAX_CYCLES, default 100: count period, legal range >=2.
REQ-004 The block SHALL have port clk, input, 1 bit: the only clock, rising-edge active.
REQ-005 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port fizz, output, 1 bit: high while the current count is divisible by FIZZ.
REQ-007 The block SHALL have port buzz, output, 1 bit: high while the current count is divisible by BUZZ.
REQ-008 The block SHALL have port fizzbuzz, output, 1 bit: high while the current count is divisible by both FIZZ and BUZZ.

Function
REQ-009 The block SHALL hold an internal count of width max(1, $clog2(MAX_CYCLES)) bits.
REQ-010 The count SHALL advance by 1 on every rising clk edge while resetn is high, with no enable or stall.
REQ-011 The count SHALL wrap from MAX_CYCLES-1 to 0 on the next edge.
REQ-012 The block SHALL NOT use a divider or modulo operator for divisibility; it SHALL track count mod FIZZ and count mod BUZZ in residue counters.
REQ-013 Each residue counter SHALL increment with the count, wrap at its divisor-1 back to 0, and also return to 0 when the main count wraps.
REQ-014 Outputs SHALL be registered and SHALL reflect the count value held after the same edge, with zero added cycles of latency versus the count.
REQ-015 fizz SHALL equal (count mod FIZZ == 0).
REQ-016 buzz SHALL equal (count mod BUZZ == 0).
REQ-017 fizzbuzz SHALL equal fizz AND buzz.
REQ-018 Count 0 is divisible by every divisor, so all three outputs SHALL be high whenever count is 0, including directly after reset and after every wrap.

Reset
REQ-019 Asserting resetn low SHALL immediately, without waiting for a clock edge, set the count and both residue counters to 0 and drive fizz=1, buzz=1, fizzbuzz=1.
REQ-020 The first rising edge with resetn high SHALL produce count=1 with all outputs low.
REQ-021 Reset asserted mid-count SHALL restart the sequence from 0 with no residual state.

Configuration
REQ-022 When macro MODEL_EXCLUSIVE_EN is defined, fizz and buzz SHALL be forced low whenever fizzbuzz is high, giving mutually exclusive outputs, and reset SHALL then drive fizz=0, buzz=0, fizzbuzz=1.
REQ-023 When MODEL_EXCLUSIVE_EN is not defined, the behaviour SHALL be exactly REQ-015 to REQ-019.

Structure
REQ-024 The shared package model_pkg SHALL hold the default parameter constants and a function computing the count width.
REQ-025 The block SHALL instantiate one sub-module, mod_counter (parameter MOD, ports clk, resetn, clr, inc, zero), twice: once with MOD=FIZZ and once with MOD=BUZZ.

Verification
REQ-026 Reset with MAX_CYCLES=30, then release -> during reset fizz=buzz=fizzbuzz=1; at count 1 all outputs 0.
REQ-027 Run 30 cycles with MAX_CYCLES=30 -> fizz only at counts 3,6,9,12,18,21,24,27; buzz only at 5,10,20,25; all three at 0 and 15.
REQ-028 MAX_CYCLES=7, FIZZ=3, BUZZ=5 -> after count 6, count wraps to 0 with all outputs 1; at count 1 fizz=0 (residues cleared on wrap).
REQ-029 Assert resetn asynchronously at count 13 -> outputs go to 1,1,1 before the next edge; after release the sequence restarts at count 1.
REQ-030 MODEL_EXCLUSIVE_EN defined, MAX_CYCLES=30 -> at count 15 fizz=0, buzz=0, fizzbuzz=1; at count 3 fizz=1.
REQ-031 Random reset pulses over 1000 cycles -> outputs always match a reference model computing count%FIZZ and count%BUZZ.

Source files
------------

// File: rtl/model_pkg.sv
// Shared constants and helpers for the fizz/buzz counter block.
package model_pkg;

  localparam int DEF_FIZZ       = 3;
  localparam int DEF_BUZZ       = 5;
  localparam int DEF_MAX_CYCLES = 100;

  // Register width needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Residue counter: tracks (count mod MOD) and flags, registered, when it is zero.
module mod_counter
  import model_pkg::*;
#(
  parameter int MOD = DEF_FIZZ
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic inc,
  output logic zero
);

  localparam int              RW   = cnt_width(MOD);
  localparam logic [RW-1:0]   LAST = RW'(MOD - 1);

  logic [RW-1:0] res;
  logic [RW-1:0] res_nxt;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    res_nxt = res;
    if (clr)
      res_nxt = '0;
    else if (inc)
      res_nxt = (res == LAST) ? '0 : res + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res  <= '0;
      zero <= 1'b1;
    end else begin
      res  <= res_nxt;
      zero <= (res_nxt == '0);
    end
  end

endmodule

// File: rtl/model.sv
// Free-running fizz/buzz detector; define MODEL_EXCLUSIVE_EN to make fizz/buzz
// drop out whenever fizzbuzz is high.
module model
  import model_pkg::*;
#(
  parameter int FIZZ       = DEF_FIZZ,
  parameter int BUZZ       = DEF_BUZZ,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  output logic fizz,
  output logic buzz,
  output logic fizzbuzz
);

  localparam int            CW   = cnt_width(MAX_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MAX_CYCLES - 1);

  logic [CW-1:0] count;
  logic          wrap;
  logic          fizz_zero;
  logic          buzz_zero;

  assign wrap = (count == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      count <= '0;
    else
      count <= wrap ? '0 : count + 1'b1;
  end

  // Residues are cleared on wrap so they stay in step when MAX_CYCLES is not
  // a multiple of the divisor.
  mod_counter #(.MOD(FIZZ)) u_fizz_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (wrap),
    .inc    (1'b1),
    .zero   (fizz_zero)
  );

  mod_counter #(.MOD(BUZZ)) u_buzz_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (wrap),
    .inc    (1'b1),
    .zero   (buzz_zero)
  );

  assign fizzbuzz = fizz_zero & buzz_zero;

`ifdef MODEL_EXCLUSIVE_EN
  assign fizz = fizz_zero & ~buzz_zero;
  assign buzz = buzz_zero & ~fizz_zero;
`else
  assign fizz = fizz_zero;
  assign buzz = buzz_zero;
`endif

endmodule

// File: tb/tb_model.sv
// Directed and random-reset checks for model at MAX_CYCLES=30 and MAX_CYCLES=7.
module tb_model;

  logic clk;
  logic resetn_tb;
  logic fizz30, buzz30, fizzbuzz30;
  logic fizz7, buzz7, fizzbuzz7;

  int n_cmp = 0;
  int n_err = 0;
  int c30   = 0;
  int c7    = 0;

  model #(.FIZZ(3), .BUZZ(5), .MAX_CYCLES(30)) dut30 (
    .clk      (clk),
    .resetn   (resetn_tb),
    .fizz     (fizz30),
    .buzz     (buzz30),
    .fizzbuzz (fizzbuzz30)
  );

  model #(.FIZZ(3), .BUZZ(5), .MAX_CYCLES(7)) dut7 (
    .clk      (clk),
    .resetn   (resetn_tb),
    .fizz     (fizz7),
    .buzz     (buzz7),
    .fizzbuzz (fizzbuzz7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies the mutually-exclusive output rule when that build option is on.
  function automatic logic [2:0] excl(input logic [2:0] v);
`ifdef MODEL_EXCLUSIVE_EN
    if (v[0]) return 3'b001;
`endif
    return v;
  endfunction

  // Hand-written table of {fizz,buzz,fizzbuzz} for FIZZ=3, BUZZ=5, counts 0..29.
  function automatic logic [2:0] table_exp(input int c);
    case (c)
      0, 15:                          return excl(3'b111);
      3, 6, 9, 12, 18, 21, 24, 27:    return excl(3'b100);
      5, 10, 20, 25:                  return excl(3'b010);
      default:                        return 3'b000;
    endcase
  endfunction

  // Arithmetic reference used for the random-reset run.
  function automatic logic [2:0] model_exp(input int c);
    logic f, b;
    f = (c % 3) == 0;
    b = (c % 5) == 0;
    return excl({f, b, f & b});
  endfunction

  // One rising edge, then settle 2 time units past it; advances the reference counts.
  task automatic tick();
    @(posedge clk);
    #2;
    c30 = (c30 + 1) % 30;
    c7  = (c7 + 1) % 7;
  endtask

  // Called 2 units after an edge: asserts reset asynchronously, then releases it before the next edge.
  task automatic pulse_reset();
    resetn_tb = 1'b0;
    #1;
    c30 = 0;
    c7  = 0;
    #2;
    resetn_tb = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] obs;
    logic [2:0] rst_exp;
    rst_exp = excl(3'b111);
    #12;
    obs = {fizz30, buzz30, fizzbuzz30};
    n_cmp++;
    if (obs !== rst_exp) begin
      n_err++;
      $display("FAIL reset_hold30 got=%b want=%b", obs, rst_exp);
    end
    obs = {fizz7, buzz7, fizzbuzz7};
    n_cmp++;
    if (obs !== rst_exp) begin
      n_err++;
      $display("FAIL reset_hold7 got=%b want=%b", obs, rst_exp);
    end
    resetn_tb = 1'b1;
    c30 = 0;
    c7  = 0;
    tick();
    obs = {fizz30, buzz30, fizzbuzz30};
    n_cmp++;
    if (obs !== 3'b000) begin
      n_err++;
      $display("FAIL first_edge30 got=%b want=000", obs);
    end
    obs = {fizz7, buzz7, fizzbuzz7};
    n_cmp++;
    if (obs !== 3'b000) begin
      n_err++;
      $display("FAIL first_edge7 got=%b want=000", obs);
    end
  endtask

  // Walks counts 2..29, the wrap to 0 and back to 1 on the MAX_CYCLES=30 instance.
  task automatic test_sequence();
    logic [2:0] obs;
    logic [2:0] exp;
    for (int i = 0; i < 30; i++) begin
      tick();
      exp = table_exp(c30);
      obs = {fizz30, buzz30, fizzbuzz30};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL seq30 count=%0d got=%b want=%b", c30, obs, exp);
      end
    end
  endtask

  // MAX_CYCLES=7: counts 1..6, wrap to 0, then 1 again.
  task automatic test_wrap();
    logic [2:0] obs;
    logic [2:0] exp;
    logic [2:0] wrap_exp [8];
    wrap_exp = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b010, 3'b100, 3'b111, 3'b000};
    tick();
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = excl(wrap_exp[i]);
      obs = {fizz7, buzz7, fizzbuzz7};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL wrap7 step=%0d got=%b want=%b", i + 1, obs, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] obs;
    logic [2:0] rst_exp;
    rst_exp = excl(3'b111);
    tick();
    pulse_reset();
    for (int i = 0; i < 13; i++) tick();
    obs = {fizz30, buzz30, fizzbuzz30};
    n_cmp++;
    if (obs !== 3'b000) begin
      n_err++;
      $display("FAIL count13 got=%b want=000", obs);
    end
    resetn_tb = 1'b0;
    #1;
    c30 = 0;
    c7  = 0;
    obs = {fizz30, buzz30, fizzbuzz30};
    n_cmp++;
    if (obs !== rst_exp) begin
      n_err++;
      $display("FAIL async_reset30 got=%b want=%b", obs, rst_exp);
    end
    obs = {fizz7, buzz7, fizzbuzz7};
    n_cmp++;
    if (obs !== rst_exp) begin
      n_err++;
      $display("FAIL async_reset7 got=%b want=%b", obs, rst_exp);
    end
    #2;
    resetn_tb = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      obs = {fizz30, buzz30, fizzbuzz30};
      n_cmp++;
      if (obs !== table_exp(i)) begin
        n_err++;
        $display("FAIL restart30 count=%0d got=%b want=%b", i, obs, table_exp(i));
      end
    end
  endtask

  task automatic test_random_reset();
    logic [2:0] obs;
    logic [2:0] rst_exp;
    rst_exp = excl(3'b111);
    for (int cyc = 0; cyc < 1000; cyc++) begin
      tick();
      if ($urandom_range(0, 39) == 0) begin
        resetn_tb = 1'b0;
        #1;
        c30 = 0;
        c7  = 0;
        obs = {fizz30, buzz30, fizzbuzz30};
        n_cmp++;
        if (obs !== rst_exp) begin
          n_err++;
          $display("FAIL rand_reset30 cyc=%0d got=%b want=%b", cyc, obs, rst_exp);
        end
        #2;
        resetn_tb = 1'b1;
      end else begin
        obs = {fizz30, buzz30, fizzbuzz30};
        n_cmp++;
        if (obs !== model_exp(c30)) begin
          n_err++;
          $display("FAIL rand30 cyc=%0d count=%0d got=%b want=%b", cyc, c30, obs, model_exp(c30));
        end
        obs = {fizz7, buzz7, fizzbuzz7};
        n_cmp++;
        if (obs !== model_exp(c7)) begin
          n_err++;
          $display("FAIL rand7 cyc=%0d count=%0d got=%b want=%b", cyc, c7, obs, model_exp(c7));
        end
      end
    end
  endtask

  initial begin
    resetn_tb = 1'b0;
    test_reset();
    test_sequence();
    test_wrap();
    test_async_reset();
    test_random_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
